bp_resolve_update: RTL and testbench
====================================

Name: bp_resolve_update

Overview:
- Back end of the two-level adaptive branch predictor.
- Holds a FIFO of in-flight prediction records pushed by the fetch side.
- Pops them in order as the execute stage resolves branches, and computes the new local history and 2-bit PHT counter.
- Drives a registered write-back to the history and pattern tables, plus a one-cycle mispredict pulse that flushes younger records.

Parameters:
- DEPTH, 8, in-flight record FIFO entries; power of two, ≥2.
- PC_IDX_W, 3, width of the history-table index taken from the PC.
- HIST_W, 3, local history width; also the PHT index width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- push_v_i  in  1  prediction record valid.
- push_ready_o  out  1  record accepted when push_v_i & push_ready_o.
- push_pc_idx_i  in  PC_IDX_W  history-table index of the branch.
- push_hist_i  in  HIST_W  local history used for the prediction.
- push_ctr_i  in  2  PHT counter value read at prediction.
- push_pred_i  in  1  predicted direction (1 = taken).
- resolve_v_i  in  1  oldest branch resolved.
- resolve_ready_o  out  1  resolve accepted when resolve_v_i & resolve_ready_o.
- resolve_taken_i  in  1  actual direction.
- flush_i  in  1  external pipeline flush.
- upd_v_o  out  1  table write strobe, one cycle.
- upd_pc_idx_o  out  PC_IDX_W  history-table write index.
- upd_hist_o  out  HIST_W  new local history; also the restore value.
- upd_pht_idx_o  out  HIST_W  PHT write index (old history).
- upd_ctr_o  out  2  new PHT counter.
- mispredict_o  out  1  resolved direction differed from prediction.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (asynchronous, active-low):
  - FIFO empty, pointers 0, state RUN.
  - All outputs 0, except push_ready_o = 1 once reset_n_i is high.
- States:
  - RUN: normal operation.
  - FLUSH: entered only after a mispredict; lasts exactly one cycle, then returns to RUN.
- Handshake readiness:
  - push_ready_o = (state==RUN) & !full & !flush_i.
  - resolve_ready_o = (state==RUN) & !empty & !flush_i.
- Accepted push: writes the record at the write pointer; write pointer increments mod DEPTH.
- Accepted resolve: pops the head; read pointer increments mod DEPTH. On the next cycle:
  - upd_v_o = 1.
  - upd_pc_idx_o = head.pc_idx.
  - upd_pht_idx_o = head.hist.
  - upd_hist_o = {head.hist[HIST_W-2:0], resolve_taken_i}.
  - upd_ctr_o: taken → min(ctr+1, 3); not taken → max(ctr−1, 0). Saturating, never wraps.
  - mispredict_o = (resolve_taken_i != head.pred).
  - Latency resolve → upd_v_o is exactly 1 cycle; all update outputs are registered and held 0 when upd_v_o = 0.
- Mispredicting resolve:
  - At that clock edge the whole FIFO is emptied: pointers reset, count 0.
  - A push accepted in the same cycle is discarded and not stored.
  - Next state is FLUSH, in which both ready outputs are 0 while upd_v_o/mispredict_o are asserted.
- flush_i:
  - Both readies are forced to 0 that cycle, so no handshake completes.
  - FIFO is emptied at the edge.
  - An update already registered from the previous cycle is still presented; flush_i does not suppress upd_v_o.
  - In FLUSH, flush_i is harmless.
- Occupancy corner cases:
  - Full FIFO with push and resolve in the same cycle: push is not accepted (full is evaluated before the pop).
  - Empty FIFO: resolve_ready_o = 0; a push still completes.
  - Push and correct-predict resolve in the same cycle: count_o unchanged.
- Pointer wrap: pointers carry one extra bit so full and empty are distinguishable; count_o = wptr − rptr.

Optional Feature:
- Macro: BP_RESOLVE_STATS_EN.
- When defined, two ports are added:
  - stat_resolved_o (32, out): increments on every accepted resolve.
  - stat_mispred_o (32, out): increments on every mispredicting resolve.
  - Both wrap at 2^32, reset to 0, and update the same cycle as upd_v_o.
- When undefined, the ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset, then push 8 records with no resolves → push_ready_o = 0 after the 8th and count_o = 8. A 9th push_v_i is not accepted; count_o stays 8.
- Correctly predicted taken resolve, head = {pc_idx 5, hist 3'b010, ctr 2, pred 1} → next cycle: upd_v_o = 1, pc_idx 5, pht_idx 3'b010, hist 3'b101, ctr 3, mispredict_o = 0.
- Counter saturation:
  - Taken resolve with ctr 3 → upd_ctr_o = 3.
  - Not-taken resolve with ctr 0 → upd_ctr_o = 0, mispredict_o = 0 when pred = 0.
- Push 4 records, then a not-taken resolve of a record with pred = 1 and ctr 2:
  - Next cycle: mispredict_o = 1, upd_ctr_o = 1, count_o = 0, both readies 0 for one cycle.
  - Then push_ready_o returns to 1.
- 20 push/resolve cycles keeping 2 entries resident → pointers wrap and updates emerge in push order. With BP_RESOLVE_STATS_EN defined and 3 injected mispredicts, stat_mispred_o = 3.
- flush_i asserted with 3 entries and resolve_v_i = 1 → resolve_ready_o = 0 and no upd_v_o follows, count_o = 0. Separately, asserting reset_n_i low mid-stream clears all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bp_resolve_update.sv
// ============================================================================
// Module   : bp_resolve_update
// Purpose  : Back end of the two-level adaptive branch predictor. Buffers
//            in-flight prediction records from fetch, pops them in order as
//            execute resolves branches, and produces a registered write-back
//            (new local history + saturating 2-bit PHT counter) together with
//            a one-cycle mispredict pulse that discards all younger records.
// Ports    : clk_i, reset_n_i (async, active-low)
//            push_*     : prediction record in (valid/ready)
//            resolve_*  : resolution of the oldest record (valid/ready)
//            flush_i    : external pipeline flush, empties the FIFO
//            upd_*      : one-cycle table write-back, zero when upd_v_o = 0
//            mispredict_o, count_o (occupancy)
// Options  : BP_RESOLVE_STATS_EN adds stat_resolved_o / stat_mispred_o
//            (32-bit wrapping event counters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_resolve_update #(
    parameter int DEPTH    = 8,
    parameter int PC_IDX_W = 3,
    parameter int HIST_W   = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       push_v_i,
    output logic                       push_ready_o,
    input  logic [PC_IDX_W-1:0]        push_pc_idx_i,
    input  logic [HIST_W-1:0]          push_hist_i,
    input  logic [1:0]                 push_ctr_i,
    input  logic                       push_pred_i,
    input  logic                       resolve_v_i,
    output logic                       resolve_ready_o,
    input  logic                       resolve_taken_i,
    input  logic                       flush_i,
    output logic                       upd_v_o,
    output logic [PC_IDX_W-1:0]        upd_pc_idx_o,
    output logic [HIST_W-1:0]          upd_hist_o,
    output logic [HIST_W-1:0]          upd_pht_idx_o,
    output logic [1:0]                 upd_ctr_o,
    output logic                       mispredict_o,
    output logic [$clog2(DEPTH):0]     count_o
`ifdef BP_RESOLVE_STATS_EN
    ,
    output logic [31:0]                stat_resolved_o,
    output logic [31:0]                stat_mispred_o
`endif
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0] c_DEPTH   = c_PTR_W'(DEPTH);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_PTR_W-1:0]  w_count;
    logic                w_full;
    logic                w_empty;

    logic [PC_IDX_W-1:0] r_mem_pc   [DEPTH];
    logic [HIST_W-1:0]   r_mem_hist [DEPTH];
    logic [1:0]          r_mem_ctr  [DEPTH];
    logic                r_mem_pred [DEPTH];

    logic [PC_IDX_W-1:0] w_head_pc;
    logic [HIST_W-1:0]   w_head_hist;
    logic [1:0]          w_head_ctr;
    logic                w_head_pred;

    logic                w_push_ready;
    logic                w_resolve_ready;
    logic                w_push_fire;
    logic                w_resolve_fire;
    logic                w_mispred;
    logic [1:0]          w_ctr_next;

    logic                r_upd_v;
    logic [PC_IDX_W-1:0] r_upd_pc;
    logic [HIST_W-1:0]   r_upd_hist;
    logic [HIST_W-1:0]   r_upd_pht;
    logic [1:0]          r_upd_ctr;
    logic                r_mispred;

    assign w_count = r_wptr - r_rptr;
    assign w_full  = (w_count == c_DEPTH);
    assign w_empty = (r_wptr == r_rptr);

    assign w_head_pc   = r_mem_pc[r_rptr[c_ADDR_W-1:0]];
    assign w_head_hist = r_mem_hist[r_rptr[c_ADDR_W-1:0]];
    assign w_head_ctr  = r_mem_ctr[r_rptr[c_ADDR_W-1:0]];
    assign w_head_pred = r_mem_pred[r_rptr[c_ADDR_W-1:0]];

    // Saturating 2-bit counter step toward the resolved direction.
    always_comb begin
        w_ctr_next = w_head_ctr;
        if (resolve_taken_i) begin
            if (w_head_ctr != 2'd3) w_ctr_next = w_head_ctr + 2'd1;
        end else begin
            if (w_head_ctr != 2'd0) w_ctr_next = w_head_ctr - 2'd1;
        end
    end

    // Handshakes and next state. Readies are held low while reset is
    // asserted so nothing upstream sees an acceptance during reset.
    always_comb begin
        w_state_next    = r_state;
        w_push_ready    = 1'b0;
        w_resolve_ready = 1'b0;
        w_push_fire     = 1'b0;
        w_resolve_fire  = 1'b0;
        w_mispred       = 1'b0;
        case (r_state)
            S_RUN: begin
                w_push_ready    = reset_n_i & ~w_full  & ~flush_i;
                w_resolve_ready = reset_n_i & ~w_empty & ~flush_i;
                w_push_fire     = push_v_i & w_push_ready;
                w_resolve_fire  = resolve_v_i & w_resolve_ready;
                w_mispred       = w_resolve_fire & (resolve_taken_i != w_head_pred);
                if (w_mispred) w_state_next = S_FLUSH;
            end
            S_FLUSH: begin
                w_state_next = S_RUN;
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= S_RUN;
        else            r_state <= w_state_next;
    end

    // Record storage needs no reset: an entry is only read once written.
    always_ff @(posedge clk_i) begin
        if (w_push_fire) begin
            r_mem_pc[r_wptr[c_ADDR_W-1:0]]   <= push_pc_idx_i;
            r_mem_hist[r_wptr[c_ADDR_W-1:0]] <= push_hist_i;
            r_mem_ctr[r_wptr[c_ADDR_W-1:0]]  <= push_ctr_i;
            r_mem_pred[r_wptr[c_ADDR_W-1:0]] <= push_pred_i;
        end
    end

    // A mispredict or flush empties the FIFO, which also drops any push
    // accepted in the same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_mispred || flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_fire)    r_wptr <= r_wptr + c_PTR_ONE;
            if (w_resolve_fire) r_rptr <= r_rptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_upd_v    <= 1'b0;
            r_upd_pc   <= '0;
            r_upd_hist <= '0;
            r_upd_pht  <= '0;
            r_upd_ctr  <= '0;
            r_mispred  <= 1'b0;
        end else if (w_resolve_fire) begin
            r_upd_v    <= 1'b1;
            r_upd_pc   <= w_head_pc;
            r_upd_hist <= {w_head_hist[HIST_W-2:0], resolve_taken_i};
            r_upd_pht  <= w_head_hist;
            r_upd_ctr  <= w_ctr_next;
            r_mispred  <= w_mispred;
        end else begin
            r_upd_v    <= 1'b0;
            r_upd_pc   <= '0;
            r_upd_hist <= '0;
            r_upd_pht  <= '0;
            r_upd_ctr  <= '0;
            r_mispred  <= 1'b0;
        end
    end

`ifdef BP_RESOLVE_STATS_EN
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispred;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_stat_resolved <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (w_resolve_fire) r_stat_resolved <= r_stat_resolved + 32'd1;
            if (w_mispred)      r_stat_mispred  <= r_stat_mispred + 32'd1;
        end
    end

    assign stat_resolved_o = r_stat_resolved;
    assign stat_mispred_o  = r_stat_mispred;
`endif

    assign push_ready_o    = w_push_ready;
    assign resolve_ready_o = w_resolve_ready;
    assign upd_v_o         = r_upd_v;
    assign upd_pc_idx_o    = r_upd_pc;
    assign upd_hist_o      = r_upd_hist;
    assign upd_pht_idx_o   = r_upd_pht;
    assign upd_ctr_o       = r_upd_ctr;
    assign mispredict_o    = r_mispred;
    assign count_o         = w_count;

endmodule

`default_nettype wire

// File: tb/tb_bp_resolve_update.sv
// ============================================================================
// Module   : tb_bp_resolve_update
// Purpose  : Self-checking bench for bp_resolve_update. A reference FIFO model
//            predicts readiness and occupancy each cycle; expected write-backs
//            are queued when a resolve is accepted and compared when the DUT
//            presents upd_v_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_resolve_update;

    localparam int DEPTH    = 8;
    localparam int PC_IDX_W = 3;
    localparam int HIST_W   = 3;

    typedef struct packed {
        logic [2:0] pc;
        logic [2:0] hist;
        logic [1:0] ctr;
        logic       pred;
    } rec_t;

    typedef struct packed {
        logic [2:0] pc;
        logic [2:0] hist;
        logic [2:0] pht;
        logic [1:0] ctr;
        logic       mis;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        push_v_i = 1'b0;
    logic        push_ready_o;
    logic [2:0]  push_pc_idx_i = '0;
    logic [2:0]  push_hist_i = '0;
    logic [1:0]  push_ctr_i = '0;
    logic        push_pred_i = 1'b0;
    logic        resolve_v_i = 1'b0;
    logic        resolve_ready_o;
    logic        resolve_taken_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        upd_v_o;
    logic [2:0]  upd_pc_idx_o;
    logic [2:0]  upd_hist_o;
    logic [2:0]  upd_pht_idx_o;
    logic [1:0]  upd_ctr_o;
    logic        mispredict_o;
    logic [3:0]  count_o;
`ifdef BP_RESOLVE_STATS_EN
    logic [31:0] stat_resolved_o;
    logic [31:0] stat_mispred_o;
`endif

    bp_resolve_update #(
        .DEPTH    (DEPTH),
        .PC_IDX_W (PC_IDX_W),
        .HIST_W   (HIST_W)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .push_v_i        (push_v_i),
        .push_ready_o    (push_ready_o),
        .push_pc_idx_i   (push_pc_idx_i),
        .push_hist_i     (push_hist_i),
        .push_ctr_i      (push_ctr_i),
        .push_pred_i     (push_pred_i),
        .resolve_v_i     (resolve_v_i),
        .resolve_ready_o (resolve_ready_o),
        .resolve_taken_i (resolve_taken_i),
        .flush_i         (flush_i),
        .upd_v_o         (upd_v_o),
        .upd_pc_idx_o    (upd_pc_idx_o),
        .upd_hist_o      (upd_hist_o),
        .upd_pht_idx_o   (upd_pht_idx_o),
        .upd_ctr_o       (upd_ctr_o),
        .mispredict_o    (mispredict_o),
        .count_o         (count_o)
`ifdef BP_RESOLVE_STATS_EN
        ,
        .stat_resolved_o (stat_resolved_o),
        .stat_mispred_o  (stat_mispred_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int   n_checks = 0;
    int   n_pass   = 0;
    rec_t mq[$];          // model of FIFO contents
    exp_t sb[$];          // expected write-backs
    logic m_fl = 1'b0;    // model: in FLUSH state
    int   m_stat_res = 0;
    int   m_stat_mis = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic set_push(input logic v, input rec_t r);
        push_v_i      = v;
        push_pc_idx_i = r.pc;
        push_hist_i   = r.hist;
        push_ctr_i    = r.ctr;
        push_pred_i   = r.pred;
    endtask

    function automatic rec_t rand_rec();
        rec_t r;
        r.pc   = 3'($urandom_range(0, 7));
        r.hist = 3'($urandom_range(0, 7));
        r.ctr  = 2'($urandom_range(0, 3));
        r.pred = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic exp_t model_update(input rec_t h, input logic t);
        exp_t e;
        e.pc   = h.pc;
        e.pht  = h.hist;
        e.hist = {h.hist[1:0], t};
        if (t) e.ctr = (h.ctr == 2'd3) ? 2'd3 : h.ctr + 2'd1;
        else   e.ctr = (h.ctr == 2'd0) ? 2'd0 : h.ctr - 2'd1;
        e.mis  = (t != h.pred);
        return e;
    endfunction

    // Advance one clock with the inputs currently driven. Readiness is checked
    // at the falling edge; after the rising edge the scoreboard and occupancy
    // are compared.
    task automatic cycle();
        logic exp_pr, exp_rr, pf, rf, mis;
        rec_t h, pr;
        exp_t e, got;
        @(negedge clk_i);
        exp_pr = reset_n_i && !m_fl && (mq.size() < DEPTH) && !flush_i;
        exp_rr = reset_n_i && !m_fl && (mq.size() > 0) && !flush_i;
        n_checks++;
        if (push_ready_o !== exp_pr)
            $display("FAIL push_ready: got %b want %b (t=%0t)", push_ready_o, exp_pr, $time);
        else n_pass++;
        n_checks++;
        if (resolve_ready_o !== exp_rr)
            $display("FAIL resolve_ready: got %b want %b (t=%0t)", resolve_ready_o, exp_rr, $time);
        else n_pass++;
        pf  = push_v_i && exp_pr;
        rf  = resolve_v_i && exp_rr;
        mis = 1'b0;
        pr  = '{pc: push_pc_idx_i, hist: push_hist_i, ctr: push_ctr_i, pred: push_pred_i};
        if (rf) begin
            h   = mq.pop_front();
            e   = model_update(h, resolve_taken_i);
            mis = e.mis;
            sb.push_back(e);
            m_stat_res++;
            if (mis) m_stat_mis++;
        end
        if (pf) mq.push_back(pr);
        if (mis || flush_i) mq.delete();
        @(posedge clk_i);
        m_fl = mis;
        #1;
        got = '{pc: upd_pc_idx_o, hist: upd_hist_o, pht: upd_pht_idx_o,
                ctr: upd_ctr_o, mis: mispredict_o};
        n_checks++;
        if (upd_v_o !== (sb.size() != 0)) begin
            $display("FAIL upd_v: got %b want %b (t=%0t)", upd_v_o, (sb.size() != 0), $time);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            n_pass++;
            n_checks++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (got !== e)
                    $display("FAIL upd_fields: got pc=%0d hist=%b pht=%b ctr=%0d mis=%b want pc=%0d hist=%b pht=%b ctr=%0d mis=%b",
                             got.pc, got.hist, got.pht, got.ctr, got.mis,
                             e.pc, e.hist, e.pht, e.ctr, e.mis);
                else n_pass++;
            end else begin
                if (got !== '0)
                    $display("FAIL upd_idle_zero: got %h want 0 (t=%0t)", got, $time);
                else n_pass++;
            end
        end
        n_checks++;
        if (count_o !== 4'(mq.size()))
            $display("FAIL count: got %0d want %0d (t=%0t)", count_o, mq.size(), $time);
        else n_pass++;
`ifdef BP_RESOLVE_STATS_EN
        n_checks++;
        if (stat_resolved_o !== 32'(m_stat_res) || stat_mispred_o !== 32'(m_stat_mis))
            $display("FAIL stats: got res=%0d mis=%0d want res=%0d mis=%0d",
                     stat_resolved_o, stat_mispred_o, m_stat_res, m_stat_mis);
        else n_pass++;
`endif
    endtask

    task automatic idle_inputs();
        set_push(1'b0, '0);
        resolve_v_i     = 1'b0;
        resolve_taken_i = 1'b0;
        flush_i         = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) begin
            set_push(1'b0, '0);
            resolve_v_i     = 1'b1;
            resolve_taken_i = mq[0].pred;
            cycle();
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        n_checks++;
        if (upd_v_o !== 1'b0 || mispredict_o !== 1'b0 || count_o !== 4'd0 ||
            resolve_ready_o !== 1'b0 || upd_ctr_o !== 2'd0)
            $display("FAIL reset_outputs: upd_v=%b mis=%b count=%0d rr=%b ctr=%0d want all 0",
                     upd_v_o, mispredict_o, count_o, resolve_ready_o, upd_ctr_o);
        else n_pass++;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (push_ready_o !== 1'b1 || count_o !== 4'd0)
            $display("FAIL reset_release: push_ready=%b count=%0d want 1 and 0", push_ready_o, count_o);
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            set_push(1'b1, rand_rec());
            cycle();
        end
        n_checks++;
        if (push_ready_o !== 1'b0 || count_o !== 4'd8)
            $display("FAIL full_state: push_ready=%b count=%0d want 0 and 8", push_ready_o, count_o);
        else n_pass++;
        set_push(1'b1, rand_rec());
        cycle();
        n_checks++;
        if (count_o !== 4'd8)
            $display("FAIL ninth_push: count=%0d want 8", count_o);
        else n_pass++;
        // Full with simultaneous push and resolve: only the pop happens.
        set_push(1'b1, rand_rec());
        resolve_v_i     = 1'b1;
        resolve_taken_i = mq[0].pred;
        cycle();
        n_checks++;
        if (count_o !== 4'd7)
            $display("FAIL full_push_pop: count=%0d want 7", count_o);
        else n_pass++;
        drain();
    endtask

    task automatic test_correct_taken();
        set_push(1'b1, '{pc: 3'd5, hist: 3'b010, ctr: 2'd2, pred: 1'b1});
        cycle();
        set_push(1'b0, '0);
        resolve_v_i     = 1'b1;
        resolve_taken_i = 1'b1;
        cycle();
        n_checks++;
        if (upd_v_o !== 1'b1 || upd_pc_idx_o !== 3'd5 || upd_pht_idx_o !== 3'b010 ||
            upd_hist_o !== 3'b101 || upd_ctr_o !== 2'd3 || mispredict_o !== 1'b0)
            $display("FAIL correct_taken: v=%b pc=%0d pht=%b hist=%b ctr=%0d mis=%b want 1 5 010 101 3 0",
                     upd_v_o, upd_pc_idx_o, upd_pht_idx_o, upd_hist_o, upd_ctr_o, mispredict_o);
        else n_pass++;
        idle_inputs();
        cycle();
    endtask

    task automatic test_saturation();
        set_push(1'b1, '{pc: 3'd1, hist: 3'b111, ctr: 2'd3, pred: 1'b1});
        cycle();
        set_push(1'b1, '{pc: 3'd2, hist: 3'b000, ctr: 2'd0, pred: 1'b0});
        resolve_v_i     = 1'b1;
        resolve_taken_i = 1'b1;
        cycle();
        n_checks++;
        if (upd_ctr_o !== 2'd3)
            $display("FAIL sat_high: ctr=%0d want 3", upd_ctr_o);
        else n_pass++;
        set_push(1'b0, '0);
        resolve_taken_i = 1'b0;
        cycle();
        n_checks++;
        if (upd_ctr_o !== 2'd0 || mispredict_o !== 1'b0 || upd_hist_o !== 3'b000)
            $display("FAIL sat_low: ctr=%0d mis=%b hist=%b want 0 0 000", upd_ctr_o, mispredict_o, upd_hist_o);
        else n_pass++;
        idle_inputs();
        cycle();
    endtask

    task automatic test_mispredict();
        set_push(1'b1, '{pc: 3'd6, hist: 3'b011, ctr: 2'd2, pred: 1'b1});
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, rand_rec());
            cycle();
        end
        // Mispredicting resolve with a push in the same cycle.
        set_push(1'b1, rand_rec());
        resolve_v_i     = 1'b1;
        resolve_taken_i = 1'b0;
        cycle();
        n_checks++;
        if (mispredict_o !== 1'b1 || upd_ctr_o !== 2'd1 || count_o !== 4'd0 ||
            push_ready_o !== 1'b0 || resolve_ready_o !== 1'b0)
            $display("FAIL mispredict: mis=%b ctr=%0d count=%0d pr=%b rr=%b want 1 1 0 0 0",
                     mispredict_o, upd_ctr_o, count_o, push_ready_o, resolve_ready_o);
        else n_pass++;
        resolve_v_i = 1'b0;
        cycle();
        n_checks++;
        if (push_ready_o !== 1'b1 || count_o !== 4'd0)
            $display("FAIL after_flush_state: push_ready=%b count=%0d want 1 0", push_ready_o, count_o);
        else n_pass++;
        idle_inputs();
        cycle();
    endtask

    task automatic test_back_to_back();
        int res_n = 0;
        int base_mis = m_stat_mis;
        int cyc = 0;
        while (res_n < 20 && cyc < 80) begin
            set_push(1'b1, rand_rec());
            resolve_v_i = (mq.size() >= 2) && !m_fl;
            if (resolve_v_i) begin
                resolve_taken_i = (res_n == 5 || res_n == 11 || res_n == 17) ? ~mq[0].pred : mq[0].pred;
                res_n++;
            end else begin
                resolve_taken_i = 1'b0;
            end
            cycle();
            cyc++;
        end
        n_checks++;
        if (res_n !== 20 || (m_stat_mis - base_mis) !== 3)
            $display("FAIL b2b_progress: resolves=%0d mispredicts=%0d want 20 3", res_n, m_stat_mis - base_mis);
        else n_pass++;
`ifdef BP_RESOLVE_STATS_EN
        n_checks++;
        if (stat_mispred_o !== 32'(base_mis + 3))
            $display("FAIL stat_mispred: got %0d want %0d", stat_mispred_o, base_mis + 3);
        else n_pass++;
`endif
        set_push(1'b0, '0);
        resolve_v_i = 1'b0;
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, rand_rec());
            cycle();
        end
        set_push(1'b1, rand_rec());
        flush_i         = 1'b1;
        resolve_v_i     = 1'b1;
        resolve_taken_i = mq[0].pred;
        #1;
        n_checks++;
        if (resolve_ready_o !== 1'b0 || push_ready_o !== 1'b0)
            $display("FAIL flush_ready: rr=%b pr=%b want 0 0", resolve_ready_o, push_ready_o);
        else n_pass++;
        cycle();
        n_checks++;
        if (upd_v_o !== 1'b0 || count_o !== 4'd0)
            $display("FAIL flush_effect: upd_v=%b count=%0d want 0 0", upd_v_o, count_o);
        else n_pass++;
        idle_inputs();
        cycle();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, rand_rec());
            cycle();
        end
        set_push(1'b0, '0);
        resolve_v_i     = 1'b1;
        resolve_taken_i = mq[0].pred;
        cycle();
        // upd_v_o is now high and count_o is 2; drop reset between edges.
        #2;
        reset_n_i = 1'b0;
        #1;
        n_checks++;
        if (upd_v_o !== 1'b0 || count_o !== 4'd0 || mispredict_o !== 1'b0 ||
            upd_pc_idx_o !== 3'd0 || upd_hist_o !== 3'd0 || resolve_ready_o !== 1'b0)
            $display("FAIL async_reset: upd_v=%b count=%0d mis=%b pc=%0d hist=%b rr=%b want all 0",
                     upd_v_o, count_o, mispredict_o, upd_pc_idx_o, upd_hist_o, resolve_ready_o);
        else n_pass++;
        idle_inputs();
        mq.delete();
        sb.delete();
        m_fl       = 1'b0;
        m_stat_res = 0;
        m_stat_mis = 0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        cycle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_correct_taken();
        test_saturation();
        test_mispredict();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
